// File: rtl/fe_bank_dispatch_if.sv
// fe_bank_dispatch_if
//   Host-request and per-bank head bus between the host front end, the bank
//   dispatcher and the command arbiter.
//   master : host/arbiter side (drives requests and ready, observes heads)
//   slave  : dispatcher side (accepts requests, presents heads)
// Signals
//   in_valid, in_type (1=read), in_data[DQ], in_addr[{row,bank,col}] : host request
//   out_busy : target queue full, request refused
//   ready[BANKS] : arbiter takes head of bank b
//   valid_o, dq_o, idx_o, ra_o, ca_o, t_o : per-bank head
//   mode_o : 0=read mode, 1=write mode
interface fe_bank_dispatch_if #(
    parameter int BANKS = 16,
    parameter int CA    = 10,
    parameter int RA    = 16,
    parameter int DQ    = 16,
    parameter int IDX   = 6
);
    localparam int BB = $clog2(BANKS);

    logic                           in_valid;
    logic                           in_type;
    logic [DQ-1:0]                  in_data;
    logic [RA+BB+CA-1:0]            in_addr;
    logic                           out_busy;
    logic [BANKS-1:0]               ready;
    logic [BANKS-1:0]               valid_o;
    logic [BANKS-1:0][DQ-1:0]       dq_o;
    logic [BANKS-1:0][IDX-1:0]      idx_o;
    logic [BANKS-1:0][RA-1:0]       ra_o;
    logic [BANKS-1:0][CA-1:0]       ca_o;
    logic [BANKS-1:0]               t_o;
    logic                           mode_o;

    modport master (
        output in_valid, in_type, in_data, in_addr, ready,
        input  out_busy, valid_o, dq_o, idx_o, ra_o, ca_o, t_o, mode_o
    );

    modport slave (
        input  in_valid, in_type, in_data, in_addr, ready,
        output out_busy, valid_o, dq_o, idx_o, ra_o, ca_o, t_o, mode_o
    );
endinterface

// File: rtl/fe_bank_dispatch.sv
// fe_bank_dispatch
//   Decodes the bank from each host request and queues it into a per-bank
//   read or write FIFO, tagging reads with a rolling index. Each bank shows
//   one head to the arbiter, taken from its read FIFO in read mode or its
//   write FIFO in write mode; the mode comes from a watermark FSM on the
//   total queued reads/writes.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fe_bank_dispatch_if.slave (host request + per-bank heads)
// Build option
//   FE_STARVE_TIMER_EN : adds a starvation timer that forces a mode change
//                        after STARVE_CYC cycles with the other side waiting.
module fe_bank_dispatch #(
    parameter int BANKS      = 16,
    parameter int DEPTH      = 4,
    parameter int CA         = 10,
    parameter int RA         = 16,
    parameter int DQ         = 16,
    parameter int IDX        = 6,
    parameter int WR_HI      = 8,
    parameter int WR_LO      = 2,
    parameter int STARVE_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    fe_bank_dispatch_if.slave  bus
);
    localparam int BB = $clog2(BANKS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(BANKS * DEPTH + 1);

    typedef struct packed {
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
        logic [RA-1:0]  ra;
        logic [CA-1:0]  ca;
    } ent_t;

    // Queue index q: 0 = write FIFOs, 1 = read FIFOs (matches in_type).
    logic [1:0][BANKS-1:0] w_push, w_pop, w_full, w_empty;
    ent_t [1:0][BANKS-1:0] w_head;
    logic [BB-1:0]         w_bank;
    logic                  w_acc;
    ent_t                  w_ent;
    logic [BANKS-1:0]      w_valid;
    logic                  w_sel;
    logic                  r_mode;
    logic [IDX-1:0]        r_idx;
    logic [TW-1:0]         r_wr_tot, r_rd_tot, w_wr_nx, w_rd_nx;
    logic                  w_to_wr, w_to_rd;

    assign w_bank       = bus.in_addr[CA +: BB];
    // Full flag only: ready never reaches out_busy, so a full queue refuses
    // a push even when it is being popped.
    assign bus.out_busy = w_full[bus.in_type][w_bank];
    assign w_acc        = bus.in_valid & ~bus.out_busy;

    assign w_ent.dq  = bus.in_type ? '0 : bus.in_data;
    assign w_ent.idx = bus.in_type ? r_idx : '0;
    assign w_ent.ra  = bus.in_addr[CA+BB +: RA];
    assign w_ent.ca  = bus.in_addr[CA-1:0];

    assign w_sel = ~r_mode;   // read FIFOs in read mode, write FIFOs in write mode

    for (genvar q = 0; q < 2; q++) begin : g_q
        for (genvar b = 0; b < BANKS; b++) begin : g_b
            ent_t          r_mem [DEPTH];
            logic [PW-1:0] r_rp, r_wp;
            logic [CW-1:0] r_cnt;

            assign w_push[q][b]  = w_acc && (bus.in_type == 1'(q)) && (w_bank == BB'(b));
            assign w_pop[q][b]   = w_valid[b] && bus.ready[b] && (w_sel == 1'(q));
            assign w_full[q][b]  = (r_cnt == CW'(DEPTH));
            assign w_empty[q][b] = (r_cnt == '0);
            assign w_head[q][b]  = r_mem[r_rp];

            always_ff @(posedge clk) begin
                if (w_push[q][b]) r_mem[r_wp] <= w_ent;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rp  <= '0;
                    r_wp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push[q][b]) r_wp <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
                    if (w_pop[q][b])  r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
                    case ({w_push[q][b], w_pop[q][b]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_out
        ent_t w_h;
        assign w_valid[b]     = ~w_empty[w_sel][b];
        assign w_h            = w_valid[b] ? w_head[w_sel][b] : '0;
        assign bus.dq_o[b]    = w_h.dq;
        assign bus.idx_o[b]   = w_h.idx;
        assign bus.ra_o[b]    = w_h.ra;
        assign bus.ca_o[b]    = w_h.ca;
        assign bus.t_o[b]     = w_valid[b] & ~r_mode;
    end
    assign bus.valid_o = w_valid;
    assign bus.mode_o  = r_mode;

    // Next-state totals: at most one push per cycle, up to one pop per bank.
    always_comb begin
        w_wr_nx = r_wr_tot;
        w_rd_nx = r_rd_tot;
        if (|w_push[0]) w_wr_nx = w_wr_nx + 1'b1;
        if (|w_push[1]) w_rd_nx = w_rd_nx + 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            w_wr_nx = w_wr_nx - TW'(w_pop[0][b]);
            w_rd_nx = w_rd_nx - TW'(w_pop[1][b]);
        end
    end

    assign w_to_wr = (w_wr_nx >= TW'(WR_HI)) || ((w_rd_nx == '0) && (w_wr_nx != '0));
    assign w_to_rd = (w_wr_nx == '0) || ((w_wr_nx <= TW'(WR_LO)) && (w_rd_nx != '0));

`ifdef FE_STARVE_TIMER_EN
    localparam int SW = $clog2(STARVE_CYC + 1);
    logic [SW-1:0] r_stv;
    logic          w_starve;
    // Counts cycles the non-selected side has been waiting.
    assign w_starve = r_mode ? (r_rd_tot != '0) : (r_wr_tot != '0);
`else
    localparam int unused_starve_cyc = STARVE_CYC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_idx    <= '0;
            r_wr_tot <= '0;
            r_rd_tot <= '0;
`ifdef FE_STARVE_TIMER_EN
            r_stv    <= '0;
`endif
        end else begin
            r_wr_tot <= w_wr_nx;
            r_rd_tot <= w_rd_nx;
            if (|w_push[1]) r_idx <= r_idx + 1'b1;
`ifdef FE_STARVE_TIMER_EN
            if ((!r_mode && w_to_wr) || (r_mode && w_to_rd)) begin
                r_mode <= ~r_mode;
                r_stv  <= '0;
            end else if (w_starve && (r_stv == SW'(STARVE_CYC - 1))) begin
                r_mode <= ~r_mode;
                r_stv  <= '0;
            end else if (w_starve) begin
                r_stv  <= r_stv + 1'b1;
            end else begin
                r_stv  <= '0;
            end
`else
            if (!r_mode && w_to_wr)     r_mode <= 1'b1;
            else if (r_mode && w_to_rd) r_mode <= 1'b0;
`endif
        end
    end
endmodule
